// File: rtl/dma_pkg.sv
// Shared types and default sizes for the memory-to-memory DMA block.
package dma_pkg;

  localparam int unsigned DMA_SIZE_DEF = 3;
  localparam int unsigned DMD_SIZE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } dma_state_t;

endpackage

// File: rtl/dma_addr_gen.sv
// Loadable address pointer with increment enable; wraps naturally at 2**AW.
module dma_addr_gen #(
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      ptr <= ptr + AW'(1);
    end
  end

endmodule

// File: rtl/dma_mem_xfer.sv
// Memory-to-memory copy engine: one read then one write per word.
// Optional running XOR of written words enabled by DMA_CHECKSUM_EN.
module dma_mem_xfer
  import dma_pkg::*;
#(
  parameter int unsigned DMA_SIZE = DMA_SIZE_DEF,
  parameter int unsigned DMD_SIZE = DMD_SIZE_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [DMA_SIZE-1:0] src_base,
  input  logic [DMA_SIZE-1:0] dst_base,
  input  logic [DMA_SIZE:0]   count,
  output logic                busy,
  output logic                done,
  output logic                src_cslt,
  output logic                src_wrb,
  output logic [DMA_SIZE-1:0] src_add,
  input  logic [DMD_SIZE-1:0] src_dt,
  output logic                dst_cslt,
  output logic                dst_wrb,
  output logic [DMA_SIZE-1:0] dst_add,
  output logic [DMD_SIZE-1:0] dst_dt
`ifdef DMA_CHECKSUM_EN
  ,
  output logic [DMD_SIZE-1:0] checksum
`endif
);

  localparam int unsigned CW = DMA_SIZE + 1;

  dma_state_t           state, next_state;
  logic [CW-1:0]        remaining;
  logic [DMA_SIZE-1:0]  src_ptr, dst_ptr;
  logic                 accept, step;

  assign accept = (state == IDLE) && start;
  assign step   = (state == WR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
    end else begin
      state <= next_state;
      if (accept) begin
        remaining <= count;
      end else if (step) begin
        remaining <= remaining - CW'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start) next_state = (count != '0) ? RD : DONE;
      RD:   next_state = WR;
      WR:   next_state = (remaining == CW'(1)) ? DONE : RD;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are masked by rst so an access in the reset cycle is aborted, not completed.
  always_comb begin
    src_cslt = 1'b0;
    src_wrb  = 1'b0;
    src_add  = '0;
    dst_cslt = 1'b0;
    dst_wrb  = 1'b0;
    dst_add  = '0;
    dst_dt   = '0;
    unique case (state)
      RD: begin
        src_cslt = !rst;
        src_add  = src_ptr;
      end
      WR: begin
        dst_cslt = !rst;
        dst_wrb  = !rst;
        dst_add  = dst_ptr;
        dst_dt   = src_dt;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  dma_addr_gen #(.AW(DMA_SIZE)) u_src_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (src_base),
    .inc      (step),
    .ptr      (src_ptr)
  );

  dma_addr_gen #(.AW(DMA_SIZE)) u_dst_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (dst_base),
    .inc      (step),
    .ptr      (dst_ptr)
  );

`ifdef DMA_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      checksum <= '0;
    end else if (step) begin
      checksum <= checksum ^ src_dt;
    end
  end
`endif

endmodule

// File: tb/tb_dma_mem_xfer.sv
// Directed bench for dma_mem_xfer with behavioural source/destination memories.
module tb_dma_mem_xfer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] src_base, dst_base;
  logic [3:0] count;
  logic       busy, done;
  logic       src_cslt, src_wrb, dst_cslt, dst_wrb;
  logic [2:0] src_add, dst_add;
  logic [3:0] src_dt, dst_dt;
`ifdef DMA_CHECKSUM_EN
  logic [3:0] checksum;
`endif

  logic [3:0] src_mem [8];
  logic [3:0] dst_mem [8];
  logic [3:0] src_rd;
  int         wr_cnt, cslt_cnt;
  int         checks, failures;

  always #5 clk = ~clk;

  dma_mem_xfer #(.DMA_SIZE(3), .DMD_SIZE(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .src_cslt (src_cslt),
    .src_wrb  (src_wrb),
    .src_add  (src_add),
    .src_dt   (src_dt),
    .dst_cslt (dst_cslt),
    .dst_wrb  (dst_wrb),
    .dst_add  (dst_add),
    .dst_dt   (dst_dt)
`ifdef DMA_CHECKSUM_EN
    ,
    .checksum (checksum)
`endif
  );

  assign src_dt = src_rd;

  always @(posedge clk) begin
    if (src_cslt && !src_wrb) src_rd <= src_mem[src_add];
    if (dst_cslt && dst_wrb) begin
      dst_mem[dst_add] <= dst_dt;
      wr_cnt <= wr_cnt + 1;
    end
    if (src_cslt || dst_cslt) cslt_cnt <= cslt_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dst();
    for (int i = 0; i < 8; i++) dst_mem[i] = '0;
    wr_cnt   = 0;
    cslt_cnt = 0;
  endtask

  // Issues a one-cycle start; returns the cycle index at which done is seen.
  task automatic run_xfer(input logic [2:0] sb, input logic [2:0] db,
                          input logic [3:0] cnt, output int lat);
    src_base = sb;
    dst_base = db;
    count    = cnt;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat;
    checks = 0; failures = 0;
    rst = 1'b1; start = 1'b0; src_base = '0; dst_base = '0; count = '0;
    src_rd = '0;
    clear_dst();
    tick(); tick();
    rst = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_strobes", {src_cslt, src_wrb, dst_cslt, dst_wrb}, 0);
    check("rst_bus", {src_add, dst_add, dst_dt}, 0);
`ifdef DMA_CHECKSUM_EN
    check("rst_csum", checksum, 0);
`endif

    // Full-memory copy
    for (int i = 0; i < 8; i++) src_mem[i] = 4'(i + 1);
    clear_dst();
    run_xfer(3'd0, 3'd0, 4'd8, lat);
    check("full_latency", lat, 17);
    check("full_busy_at_done", busy, 1);
    for (int i = 0; i < 8; i++) check($sformatf("full_dst%0d", i), dst_mem[i], i + 1);
    check("full_wr_cnt", wr_cnt, 8);
    tick();
    check("full_done_pulse", {busy, done}, 0);

    // Both pointers wrap
    src_mem = '{4'h9, 4'h2, 4'h7, 4'h4, 4'hB, 4'hC, 4'hE, 4'h5};
    clear_dst();
    run_xfer(3'd6, 3'd5, 4'd4, lat);
    check("wrap_latency", lat, 9);
    check("wrap_dst5", dst_mem[5], 4'hE);
    check("wrap_dst6", dst_mem[6], 4'h5);
    check("wrap_dst7", dst_mem[7], 4'h9);
    check("wrap_dst0", dst_mem[0], 4'h2);
    check("wrap_dst4_untouched", dst_mem[4], 0);
    check("wrap_dst1_untouched", dst_mem[1], 0);
    tick();

    // Zero-length transfer
    clear_dst();
    run_xfer(3'd3, 3'd3, 4'd0, lat);
    check("zero_latency", lat, 1);
    check("zero_busy", busy, 1);
    tick();
    check("zero_cslt_cnt", cslt_cnt, 0);
    check("zero_idle", busy, 0);

    // Reset during the second write cycle
    clear_dst();
    src_base = 3'd0; dst_base = 3'd0; count = 4'd4; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("rstmid_in_wr", {dst_cslt, dst_wrb, dst_add}, {1'b1, 1'b1, 3'd1});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstmid_busy", busy, 0);
    check("rstmid_strobes", {src_cslt, dst_cslt, dst_wrb}, 0);
    tick();
    check("rstmid_wr_cnt", wr_cnt, 1);
    check("rstmid_dst0", dst_mem[0], 4'h9);
    check("rstmid_dst1", dst_mem[1], 0);
    check("rstmid_still_idle", busy, 0);

    // Start while busy is ignored, including in the DONE cycle
    clear_dst();
    src_base = 3'd0; dst_base = 3'd4; count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    src_base = 3'd7; dst_base = 3'd0; count = 4'd8; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 3;
    while (!done && lat < 100) begin
      tick();
      lat++;
    end
    check("busy_start_latency", lat, 7);
    start = 1'b1; count = 4'd2;
    tick();
    start = 1'b0;
    check("done_start_ignored", busy, 0);
    tick();
    check("done_start_still_idle", busy, 0);
    check("busy_start_dst4", dst_mem[4], 4'h9);
    check("busy_start_dst5", dst_mem[5], 4'h2);
    check("busy_start_dst6", dst_mem[6], 4'h7);
    check("busy_start_dst0", dst_mem[0], 0);
    check("busy_start_wr_cnt", wr_cnt, 3);

`ifdef DMA_CHECKSUM_EN
    src_mem[0] = 4'd3; src_mem[1] = 4'd5; src_mem[2] = 4'd6;
    clear_dst();
    src_base = 3'd0; dst_base = 3'd0; count = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    check("csum_cleared", checksum, 0);
    tick(); tick();
    check("csum_after_w0", checksum, 4'd3);
    tick(); tick();
    check("csum_after_w1", checksum, 4'd6);
    tick(); tick();
    check("csum_done", {done, checksum}, {1'b1, 4'd0});
    tick(); tick();
    check("csum_stable", checksum, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_mem_xfer.md
DMA_MEM_XFER -- requirements
Module: dma_mem_xfer

Interface
REQ-001 Parameter DMA_SIZE, default 3, is the external memory address width.
REQ-002 Parameter DMD_SIZE, default 4, is the external memory data width.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port start, input, 1 bit: one-cycle request to begin a transfer; sampled only in IDLE.
REQ-006 Port src_base, input, DMA_SIZE bits: first source address, latched on accepted start.
REQ-007 Port dst_base, input, DMA_SIZE bits: first destination address, latched on accepted start.
REQ-008 Port count, input, DMA_SIZE+1 bits: word count, 0 to 2**DMA_SIZE, latched on accepted start.
REQ-009 Port busy, output, 1 bit: high from the cycle after an accepted start until DONE is left.
REQ-010 Port done, output, 1 bit: one-cycle completion pulse.
REQ-011 Ports src_cslt, src_wrb, src_add (outputs: 1, 1 and DMA_SIZE bits) and src_dt (input, DMD_SIZE bits) form the source memory bus.
REQ-012 Ports dst_cslt, dst_wrb, dst_add (outputs: 1, 1 and DMA_SIZE bits) and dst_dt (output, DMD_SIZE bits) form the destination memory bus.

Function
REQ-013 The block SHALL be the initiator for the external memory protocol: cslt=1 with wrb=1 writes on the same edge; cslt=1 with wrb=0 issues a read whose data is valid on the memory output during the following cycle only.
REQ-014 States SHALL be IDLE, RD, WR and DONE.
- IDLE: start=1 with count>0 -> RD; start=1 with count=0 -> DONE.
- RD -> WR.
- WR -> RD if words remain, else DONE.
- DONE -> IDLE after one cycle.
REQ-015 In RD, outputs SHALL be src_cslt=1, src_wrb=0 and src_add=current source pointer; all dst strobes SHALL be 0.
REQ-016 In WR, outputs SHALL be dst_cslt=1, dst_wrb=1, dst_add=current destination pointer and dst_dt=src_dt (combinational path from the read data valid in that cycle); src_cslt SHALL be 0.
REQ-017 At the end of each WR cycle, both pointers SHALL increment by 1 modulo 2**DMA_SIZE (wrap from 2**DMA_SIZE-1 to 0), and the remaining count SHALL decrement by 1.
REQ-018 Throughput SHALL be 2 cycles per word; a count=N transfer SHALL assert done exactly 2N+1 cycles after the start cycle (N>0), and 1 cycle after it for N=0.
REQ-019 start SHALL be ignored outside IDLE; a start in the same cycle that DONE returns to IDLE SHALL also be ignored.
REQ-020 When no bus access is in progress, src_cslt, src_wrb, dst_cslt and dst_wrb SHALL be 0; src_add, dst_add and dst_dt SHALL be 0 except in RD and WR respectively.
REQ-021 done SHALL be high only in DONE; busy SHALL be high in RD, WR and DONE.

Reset
REQ-022 rst=1 SHALL, on the next rising clk edge, force IDLE, clear the pointers and the remaining count, drive busy=0 and done=0, and drive all bus strobes to 0, even mid-transfer; no write SHALL be issued in the cycle following reset.

Configuration
REQ-023 With DMA_CHECKSUM_EN defined, an output port checksum (DMD_SIZE bits) SHALL hold the XOR of all words written in the current transfer; it SHALL be cleared on accepted start and on reset, and SHALL be stable from done until the next start.
REQ-024 Without DMA_CHECKSUM_EN, the checksum port and its logic SHALL be absent.

Structure
REQ-025 Package dma_pkg SHALL hold the state encoding and the default DMA_SIZE and DMD_SIZE constants.
REQ-026 A sub-module dma_addr_gen (loadable wrapping pointer with increment enable) SHALL be instantiated twice, once for the source pointer and once for the destination pointer.

Verification
REQ-027 The bench SHALL cover the following scenarios:
- src memory preloaded 0..7 = 1..8; start with src_base=0, dst_base=0, count=8 -> dst holds 1..8; done at cycle 17 after start.
- src_base=6, dst_base=5, count=4 -> src addresses 6,7,0,1 copied to dst 5,6,7,0 (both pointers wrap).
- count=0 -> no cslt asserted; done one cycle after start.
- rst asserted during the second WR cycle -> IDLE next edge; only one word written; busy=0.
- start pulsed while busy -> ignored; transfer completes unchanged.
- DMA_CHECKSUM_EN defined, words 3,5,6 -> checksum=0 at done.
